imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the RISC-V decode stage. It covers every RV32I/RV64I immediate format (I, S, B, U, J, plus shift-amount), sign-extends to XLEN, and flags unrecognised opcodes. Instructions enter and leave through valid/ready handshakes, with a 2-entry skid buffer, so the block can sit between fetch and the register-read stage. A sideband tag (for example the PC) travels with each instruction.

---
 rtl/riscv_imm_pkg.sv | 35 +++
 rtl/imm_decode_comb.sv | 81 ++++++++
 rtl/imm_gen_pipe.sv | 109 ++++++++++
 tb/tb_imm_gen_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_imm_pkg.sv
// ============================================================================
// riscv_imm_pkg : opcodes and immediate-format encoding for imm_gen_pipe
// Revision 1.0
// ============================================================================
`default_nettype none

package riscv_imm_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_NONE = 3'd7
  } imm_fmt_t;

endpackage

`default_nettype wire

// File: rtl/imm_decode_comb.sv
// ============================================================================
// imm_decode_comb : combinational RISC-V immediate extraction and extension
// Revision 1.0
// ============================================================================
`default_nettype none

module imm_decode_comb
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt,
  output logic            illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [5:0] w_shamt;
  logic       w_sign;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_sign   = instr[31];

  // RV64 widens shamt by one bit into what RV32 treats as funct7[0]
  generate
    if (XLEN == 64) begin : g_shamt64
      assign w_shamt = instr[25:20];
    end else begin : g_shamt32
      assign w_shamt = {1'b0, instr[24:20]};
    end
  endgenerate

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (w_opcode)
      OPC_OP_IMM: begin
        if (w_funct3 == F3_SLLI || w_funct3 == F3_SRLI_SRAI) begin
          imm = {{(XLEN-6){1'b0}}, w_shamt};
          fmt = FMT_SH;
        end else begin
          imm = {{(XLEN-12){w_sign}}, instr[31:20]};
          fmt = FMT_I;
        end
      end
      OPC_LOAD, OPC_JALR: begin
        imm = {{(XLEN-12){w_sign}}, instr[31:20]};
        fmt = FMT_I;
      end
      OPC_STORE: begin
        imm = {{(XLEN-12){w_sign}}, instr[31:25], instr[11:7]};
        fmt = FMT_S;
      end
      OPC_BRANCH: begin
        imm = {{(XLEN-13){w_sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        fmt = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm = {{(XLEN-32){w_sign}}, instr[31:12], 12'b0};
        fmt = FMT_U;
      end
      OPC_JAL: begin
        imm = {{(XLEN-21){w_sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        fmt = FMT_J;
      end
      OPC_R: begin
        fmt = FMT_R;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// imm_gen_pipe : immediate generator behind a 2-entry valid/ready skid FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

module imm_gen_pipe
  import riscv_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_fmt_t         out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  w_imm;
  imm_fmt_t         w_fmt;
  logic             w_illegal;
  logic             w_push;
  logic             w_pop;

  // Entry 0 is always the head; entry 1 only holds data when count == 2
  logic [1:0]       r_count;
  logic [XLEN-1:0]  r_imm0, r_imm1;
  imm_fmt_t         r_fmt0, r_fmt1;
  logic             r_ill0, r_ill1;
  logic [TAG_W-1:0] r_tag0, r_tag1;

  imm_decode_comb #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (w_imm),
    .fmt     (w_fmt),
    .illegal (w_illegal)
  );

  assign in_ready  = (r_count != 2'd2) && !flush;
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 2'd0;
      r_imm0  <= '0;
      r_fmt0  <= FMT_NONE;
      r_ill0  <= 1'b0;
      r_tag0  <= '0;
      r_imm1  <= '0;
      r_fmt1  <= FMT_NONE;
      r_ill1  <= 1'b0;
      r_tag1  <= '0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_imm0 <= w_imm;
            r_fmt0 <= w_fmt;
            r_ill0 <= w_illegal;
            r_tag0 <= in_tag;
          end else begin
            r_imm1 <= w_imm;
            r_fmt1 <= w_fmt;
            r_ill1 <= w_illegal;
            r_tag1 <= in_tag;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_imm0  <= r_imm1;
          r_fmt0  <= r_fmt1;
          r_ill0  <= r_ill1;
          r_tag0  <= r_tag1;
          r_count <= r_count - 2'd1;
        end
        // Push and pop together only happen at count == 1: new entry replaces head
        2'b11: begin
          r_imm0 <= w_imm;
          r_fmt0 <= w_fmt;
          r_ill0 <= w_illegal;
          r_tag0 <= in_tag;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_imm     = r_imm0;
  assign out_fmt     = r_fmt0;
  assign out_illegal = r_ill0;
  assign out_tag     = r_tag0;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// tb_imm_gen_pipe : directed and randomized checks of imm_gen_pipe
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;
  import riscv_imm_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 32;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [XLEN-1:0]  out_imm;
  imm_fmt_t         out_fmt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal),
    .out_tag     (out_tag)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Reference decode built from signed shifts and masks of the whole word
  function automatic void ref_dec(input logic [31:0] x, output logic [31:0] imm,
                                  output logic [2:0] fmt, output logic ill);
    logic [6:0] opc;
    logic [2:0] f3;
    int sx;
    opc = x[6:0];
    f3  = x[14:12];
    sx  = signed'(x);
    imm = 32'd0;
    fmt = 3'd7;
    ill = 1'b0;
    case (opc)
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          imm = (x >> 20) & 32'd31;
          fmt = 3'd6;
        end else begin
          imm = 32'(sx >>> 20);
          fmt = 3'd1;
        end
      end
      7'h03, 7'h67: begin imm = 32'(sx >>> 20); fmt = 3'd1; end
      7'h23: begin
        imm = 32'((sx >>> 25) <<< 5) | ((x >> 7) & 32'd31);
        fmt = 3'd2;
      end
      7'h63: begin
        imm = 32'((sx >>> 31) <<< 12) | (((x >> 7) & 32'd1) << 11)
            | (((x >> 25) & 32'd63) << 5) | (((x >> 8) & 32'd15) << 1);
        fmt = 3'd3;
      end
      7'h37, 7'h17: begin imm = x & 32'hFFFFF000; fmt = 3'd4; end
      7'h6F: begin
        imm = 32'((sx >>> 31) <<< 20) | (((x >> 12) & 32'd255) << 12)
            | (((x >> 20) & 32'd1) << 11) | (((x >> 21) & 32'd1023) << 1);
        fmt = 3'd5;
      end
      7'h33: fmt = 3'd0;
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic directed(input string name, input logic [31:0] instr, input logic [31:0] eimm,
                          input logic [2:0] efmt, input logic eill, input logic [31:0] tag);
    @(negedge clk);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_tag    = tag;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_imm"}, 64'(out_imm), 64'(eimm));
    chk({name, "_fmt"}, 64'(out_fmt), 64'(efmt));
    chk({name, "_ill"}, 64'(out_illegal), 64'(eill));
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_tag = '0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_fmt", 64'(out_fmt), 64'd7);
    chk("rst_ill", 64'(out_illegal), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    directed("addi", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 32'h100);
    directed("sw",   32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 32'h104);
    directed("beq",  32'h00000463, 32'h00000008, 3'd3, 1'b0, 32'h108);
    directed("lui",  32'h123450B7, 32'h12345000, 3'd4, 1'b0, 32'h10C);
    directed("srai", 32'h4030D093, 32'h00000003, 3'd6, 1'b0, 32'h110);
    directed("ill",  32'h0000007F, 32'h00000000, 3'd7, 1'b1, 32'h114);
    directed("rtyp", 32'h002081B3, 32'h00000000, 3'd0, 1'b0, 32'h118);

    // Backpressure: tags 1, 2 accepted, 3 held until a slot frees
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'd1;
    #1 chk("bp_empty_after_directed", 64'(out_valid), 64'd0);
    chk("bp_rdy1", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_tag = 32'd2;
    #1 chk("bp_rdy2", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_tag = 32'd3;
    #1 chk("bp_full_rdy", 64'(in_ready), 64'd0);
    chk("bp_head1", 64'(out_tag), 64'd1);
    @(negedge clk);
    #1 chk("bp_hold_head", 64'(out_tag), 64'd1);
    chk("bp_hold_rdy", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    #1 chk("bp_out2", 64'(out_tag), 64'd2);
    chk("bp_rdy_back", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("bp_out3", 64'(out_tag), 64'd3);
    chk("bp_out3_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    #1 chk("bp_drained", 64'(out_valid), 64'd0);

    // Flush with a full buffer and an instruction on offer
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 32'd11;
    @(negedge clk);
    in_tag = 32'd12;
    @(negedge clk);
    flush = 1'b1; in_tag = 32'd99;
    #1 chk("fl_rdy_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1 chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_rdy", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_tag = 32'd13;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("fl_next_tag", 64'(out_tag), 64'd13);
    out_ready = 1'b1;
    @(negedge clk);
    #1 chk("fl_count_one", 64'(out_valid), 64'd0);

    // Asynchronous reset with a full buffer
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 32'd21;
    @(negedge clk);
    in_tag = 32'd22;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("ar_full", 64'(in_ready), 64'd0);
    #1 reset = 1'b1;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_rdy", 64'(in_ready), 64'd1);
    chk("ar_imm", 64'(out_imm), 64'd0);
    chk("ar_fmt", 64'(out_fmt), 64'd7);
    chk("ar_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();

    // Randomized traffic against a queue model
    for (int i = 0; i < 500; i++) begin
      logic [31:0] opcs [10];
      logic [31:0] rnd;
      ent_t e;
      bit do_push, do_pop;
      opcs = '{32'h33, 32'h13, 32'h03, 32'h23, 32'h63, 32'h37, 32'h17, 32'h6F, 32'h67, 32'h7F};
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rnd       = $urandom();
      in_instr  = (rnd & 32'hFFFFFF80) | opcs[$urandom_range(0, 9)];
      in_tag    = $urandom();
      #1;
      chk("rnd_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("rnd_ready", 64'(in_ready), 64'(q.size() < 2 && !flush));
      if (q.size() != 0) begin
        chk("rnd_imm", 64'(out_imm), 64'(q[0].imm));
        chk("rnd_fmt", 64'(out_fmt), 64'(q[0].fmt));
        chk("rnd_ill", 64'(out_illegal), 64'(q[0].ill));
        chk("rnd_tag", 64'(out_tag), 64'(q[0].tag));
      end
      if (flush) begin
        q.delete();
      end else begin
        do_push = in_valid && (q.size() < 2);
        do_pop  = out_ready && (q.size() > 0);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          ref_dec(in_instr, e.imm, e.fmt, e.ill);
          e.tag = in_tag;
          q.push_back(e);
        end
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
